// File: rtl/serial_sub_if.sv
// rtl/serial_sub_if.sv - start/ready/done handshake and operand/result bundle for serial_sub
interface serial_sub_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             b_out;

    modport master (
        output start, a, b, b_in,
        input  ready, busy, done, d, b_out
    );

    modport slave (
        input  start, a, b, b_in,
        output ready, busy, done, d, b_out
    );
endinterface

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial subtractor d = a - b - b_in, LSB first, one bit per clock
module serial_sub #(
    parameter int WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    serial_sub_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic             br;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] d_q;
    logic             b_out_q;
    logic             done_q;

    logic             x;
    logic             y;
    logic             diff;
    logic             br_next;
    logic [WIDTH-1:0] res_next;
    logic             busy;
    logic             accept;

    // One full-subtractor cell; the diff bit enters the result from the MSB end.
    assign x        = a_sr[0];
    assign y        = b_sr[0];
    assign diff     = x ^ y ^ br;
    assign br_next  = (~x & y) | (~(x ^ y) & br);
    assign res_next = {diff, res_sr};

    assign busy   = (state == SHIFT);
    assign accept = ~busy & bus.start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            br      <= 1'b0;
            cnt     <= '0;
            d_q     <= '0;
            b_out_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                state <= SHIFT;
                a_sr  <= bus.a;
                b_sr  <= bus.b;
                br    <= bus.b_in;
                cnt   <= '0;
            end else if (state == DONE) begin
                state <= IDLE;
            end

            if (busy) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                br     <= br_next;
                res_sr <= res_next[WIDTH-1:1];
                cnt    <= cnt + 1'b1;
                // Publish the whole result at once so d/b_out never show partial bits.
                if (cnt == LAST) begin
                    state   <= DONE;
                    done_q  <= 1'b1;
                    d_q     <= res_next;
                    b_out_q <= br_next;
                end
            end
        end
    end

    assign bus.ready = ~busy;
    assign bus.busy  = busy;
    assign bus.done  = done_q;
    assign bus.d     = d_q;
    assign bus.b_out = b_out_q;
endmodule
